u_maxpool: RTL and testbench
============================

# u_maxpool

Streaming 2x2, stride-2 max-pooling stage that sits directly downstream of the convolution PE array. It consumes the 8-bit, one-pixel-per-valid output stream of a PE (raster order, one output channel per instance) and produces the pooled feature map in raster order. The block is built from a half-row line buffer, a pair register and row/column counters, so no frame storage is needed.

## Interface
Parameters:
- MAP_W, 24, input feature-map width in pixels; must be even and at least 2.
- MAP_H, 24, input feature-map height in pixels; must be even and at least 2.

Ports:
- clk_cal  input  1  calculation clock; all logic on rising edge.
- rst_cal  input  1  reset; synchronous and active-high.
- IMap  input  8  input pixel, unsigned 8-bit.
- IMapVld  input  1  IMap valid, one pixel accepted per high cycle.
- OMap  output  8  pooled pixel, registered.
- OMapVld  output  1  one-cycle pulse marking OMap valid.
- FrameDone  output  1  one-cycle pulse coincident with the last pooled pixel of a frame.

## Operation
- Counters:
  - col counts 0..MAP_W-1 and row counts 0..MAP_H-1.
  - Both advance only on IMapVld cycles.
  - col wraps to 0 and increments row; row wraps to 0 after the last pixel of the frame.
  - The next frame starts immediately, with no idle cycle required.
- Operand: px = IMap after the optional clamp (see Configuration).
- Even col: pair <= px.
- Odd col, even row: linebuf[col>>1] <= max(pair, px). Nothing is emitted.
- Odd col, odd row:
  - OMap <= max(pair, px, linebuf[col>>1]).
  - OMapVld <= 1.
  - FrameDone <= 1 only when row == MAP_H-1 and col == MAP_W-1.
- linebuf: MAP_W/2 entries of 8 bits.
  - One write per odd column of an even row; one read per odd column of an odd row.
  - A read and a write never hit the same entry in the same cycle.
- Comparisons are unsigned 8-bit. Ties select either operand; the result is identical.
- Output count per frame: (MAP_W/2)*(MAP_H/2). The default configuration gives 144.
- IMapVld gaps of any length are allowed. Counters, pair and linebuf hold their values during a gap.
- No backpressure. The consumer must accept every OMapVld pulse.

## Timing
- Reset values:
  - OMap = 0, OMapVld = 0, FrameDone = 0.
  - col = 0, row = 0, pair = 0.
- linebuf is not reset. It is always written in an even row before it is read in an odd row.
- Latency: OMapVld rises on the clk_cal edge after the IMapVld cycle that carries the bottom-right pixel of a window, which is 1 cycle.
- OMapVld and FrameDone are high for exactly one cycle per pooled pixel. OMap holds its last value until the next pooled pixel.
- Maximum throughput: one input per cycle, giving one output every 2 cycles during odd rows.
- Reset mid-frame:
  - rst_cal high on an edge clears the counters, pair and all outputs on that edge.
  - A pending output is dropped.
  - The next accepted pixel is treated as row 0, col 0.
- rst_cal has priority over IMapVld in the same cycle. That pixel is discarded.

## Configuration
- POOL_RELU_EN:
  - Defined: px = IMap[7] ? 8'd0 : IMap. Inputs with the top bit set are clamped to zero before comparison, so the block tolerates sign-flagged PE outputs.
  - Undefined: px = IMap, and all 8 bits are compared as an unsigned magnitude.
- Counters, latency and output count are unchanged by this macro.

## Test plan
- Basic pooling: MAP_W=4, MAP_H=4, inputs 0..15 in raster order, continuous IMapVld -> OMap sequence 5, 7, 13, 15.
  - OMapVld pulses one cycle after inputs 5, 7, 13, 15.
  - FrameDone pulses only with the value 15.
- Gapped input: same data as the basic test, with IMapVld toggling 1/0 and random gaps of 0-5 cycles -> identical outputs 5, 7, 13, 15 with no extra pulses.
- Max position: MAP_W=4, MAP_H=4, all inputs 10 except a single 200 placed at each window position in turn -> the corresponding output is 200 and all other outputs are 10.
- Back-to-back frames: two consecutive 4x4 frames, the second with inputs 15..0 -> outputs 5, 7, 13, 15 then 15, 13, 7, 5.
  - FrameDone pulses twice.
  - No idle cycle is needed between frames.
- Reset mid-frame: assert rst_cal after 9 pixels of a 4x4 frame, then send a full frame of inputs 0..15.
  - Outputs are 0 during and after the reset cycle.
  - The new frame yields 5, 7, 13, 15 only.
- POOL_RELU_EN: 4x4 frame, all inputs 8'h85 except one 8'h03 per window.
  - Macro defined -> every output is 3.
  - Macro undefined -> every output is 8'h85.

Source files
------------

// File: rtl/u_maxpool_if.sv
// Pixel stream bundle for u_maxpool: PE output stream in, pooled stream out.
interface u_maxpool_if;
    logic [7:0] IMap;
    logic       IMapVld;
    logic [7:0] OMap;
    logic       OMapVld;
    logic       FrameDone;

    modport master (output IMap, IMapVld, input OMap, OMapVld, FrameDone);
    modport slave  (input IMap, IMapVld, output OMap, OMapVld, FrameDone);
endinterface

// File: rtl/u_maxpool.sv
// Streaming 2x2 stride-2 max pool using a half-row line buffer and a pair register.
// Optional macro POOL_RELU_EN clamps inputs with bit 7 set to zero before comparison.
module u_maxpool #(
    parameter int MAP_W = 24,
    parameter int MAP_H = 24
) (
    input  logic        clk_cal,
    input  logic        rst_cal,
    u_maxpool_if.slave  pif
);

    localparam int CW = (MAP_W > 2) ? $clog2(MAP_W) : 1;
    localparam int RW = (MAP_H > 2) ? $clog2(MAP_H) : 1;
    localparam int LW = (MAP_W > 2) ? $clog2(MAP_W / 2) : 1;

    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [7:0]    pair_q, pair_d;
    logic [7:0]    omap_q, omap_d;
    logic          ovld_q, ovld_d;
    logic          fdone_q, fdone_d;

    logic [7:0]    linebuf_q [MAP_W/2];
    logic          lb_we;
    logic [LW-1:0] lb_idx;
    logic [7:0]    lb_wdata;

    logic [7:0]    px;
    logic          col_last, row_last;

`ifdef POOL_RELU_EN
    assign px = pif.IMap[7] ? 8'd0 : pif.IMap;
`else
    assign px = pif.IMap;
`endif

    assign col_last = (col_q == CW'(MAP_W - 1));
    assign row_last = (row_q == RW'(MAP_H - 1));
    assign lb_idx   = LW'(col_q >> 1);
    assign lb_wdata = max8(pair_q, px);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        pair_d  = pair_q;
        omap_d  = omap_q;
        ovld_d  = 1'b0;
        fdone_d = 1'b0;
        lb_we   = 1'b0;

        if (pif.IMapVld) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end

            if (!col_q[0]) begin
                pair_d = px;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                omap_d  = max8(lb_wdata, linebuf_q[lb_idx]);
                ovld_d  = 1'b1;
                fdone_d = row_last && col_last;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge clk_cal) begin
        if (rst_cal) begin
            col_q   <= '0;
            row_q   <= '0;
            pair_q  <= '0;
            omap_q  <= '0;
            ovld_q  <= 1'b0;
            fdone_q <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            pair_q  <= pair_d;
            omap_q  <= omap_d;
            ovld_q  <= ovld_d;
            fdone_q <= fdone_d;
        end
    end

    // NOTE: the line buffer is deliberately not reset; an even row always fills it before it is read.
    always_ff @(posedge clk_cal) begin
        if (lb_we) begin
            linebuf_q[lb_idx] <= lb_wdata;
        end
    end

    assign pif.OMap      = omap_q;
    assign pif.OMapVld   = ovld_q;
    assign pif.FrameDone = fdone_q;

endmodule

// File: tb/tb_u_maxpool.sv
// Self-checking bench for u_maxpool (4x4 map): frame-level reference model plus literal checks.
module tb_u_maxpool;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    typedef logic [7:0] frame_t [N];

    logic clk_cal = 1'b0;
    logic rst_cal;
    always #5 clk_cal = ~clk_cal;

    u_maxpool_if pif ();

    u_maxpool #(.MAP_W(W), .MAP_H(H)) dut (
        .clk_cal (clk_cal),
        .rst_cal (rst_cal),
        .pif     (pif)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: stores the frame image and pools a window when its bottom-right pixel lands.
    logic [7:0] img [H][W];
    int         pix_idx = 0;
    logic       p_vld = 1'b0, p_fd = 1'b0;
    logic [7:0] p_omap = 8'd0;
    logic       exp_vld = 1'b0, exp_fd = 1'b0;
    logic [7:0] exp_omap = 8'd0;
    bit         cmp_en = 1'b0;

    function automatic logic [7:0] relu(input logic [7:0] d);
`ifdef POOL_RELU_EN
        return d[7] ? 8'd0 : d;
`else
        return d;
`endif
    endfunction

    function automatic logic [7:0] mx(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_step(input bit rst, input bit vld, input logic [7:0] d);
        int r, c;
        if (rst) begin
            pix_idx = 0;
            p_vld   = 1'b0;
            p_fd    = 1'b0;
            p_omap  = 8'd0;
        end else if (vld) begin
            r = pix_idx / W;
            c = pix_idx % W;
            img[r][c] = relu(d);
            p_vld = 1'b0;
            p_fd  = 1'b0;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                p_omap = mx(mx(img[r-1][c-1], img[r-1][c]), mx(img[r][c-1], img[r][c]));
                p_vld  = 1'b1;
                p_fd   = (pix_idx == N - 1);
            end
            pix_idx = (pix_idx + 1) % N;
        end else begin
            p_vld = 1'b0;
            p_fd  = 1'b0;
        end
    endtask

    // One clock: promote last cycle's prediction, then drive new inputs and predict their result.
    task automatic step(input bit rst, input bit vld, input logic [7:0] d);
        @(posedge clk_cal);
        #1;
        exp_vld  = p_vld;
        exp_fd   = p_fd;
        exp_omap = p_omap;
        rst_cal     = rst;
        pif.IMapVld = vld;
        pif.IMap    = vld ? d : 8'($urandom);
        model_step(rst, vld, d);
    endtask

    logic [7:0] out_log [$];
    int         fd_cnt = 0;

    always @(negedge clk_cal) begin
        if (cmp_en) begin
            check("omap_vld", {31'd0, pif.OMapVld}, {31'd0, exp_vld});
            check("frame_done", {31'd0, pif.FrameDone}, {31'd0, exp_fd});
            check("omap", {24'd0, pif.OMap}, {24'd0, exp_omap});
            if (pif.OMapVld) begin
                out_log.push_back(pif.OMap);
                if (pif.FrameDone) fd_cnt++;
            end
        end
    end

    task automatic send_frame(input frame_t f, input int max_gap);
        for (int i = 0; i < N; i++) begin
            step(1'b0, 1'b1, f[i]);
            repeat ($urandom_range(0, max_gap)) step(1'b0, 1'b0, 8'd0);
        end
    endtask

    task automatic flush();
        repeat (3) step(1'b0, 1'b0, 8'd0);
    endtask

    task automatic clear_log();
        out_log.delete();
        fd_cnt = 0;
    endtask

    task automatic check_log4(input string name, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3, input int exp_fd_cnt);
        logic [7:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        check({name, "_count"}, out_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < out_log.size()) check($sformatf("%s_out%0d", name, i), {24'd0, out_log[i]}, {24'd0, e[i]});
        end
        check({name, "_fd"}, fd_cnt, exp_fd_cnt);
    endtask

    frame_t f_up, f_dn, f_mp;

    initial begin
        rst_cal     = 1'b1;
        pif.IMapVld = 1'b0;
        pif.IMap    = 8'd0;
        for (int i = 0; i < N; i++) begin
            f_up[i] = 8'(i);
            f_dn[i] = 8'(N - 1 - i);
        end

        step(1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b0, 8'd0);
        cmp_en = 1'b1;
        step(1'b0, 1'b0, 8'd0);
        @(negedge clk_cal);
        check("reset_omap", {24'd0, pif.OMap}, 32'd0);
        check("reset_vld", {31'd0, pif.OMapVld}, 32'd0);
        check("reset_fd", {31'd0, pif.FrameDone}, 32'd0);

        // Basic continuous frame.
        clear_log();
        send_frame(f_up, 0);
        flush();
        check_log4("basic", 8'd5, 8'd7, 8'd13, 8'd15, 1);

        // Gapped input.
        clear_log();
        send_frame(f_up, 5);
        flush();
        check_log4("gapped", 8'd5, 8'd7, 8'd13, 8'd15, 1);

        // Single maximum at every pixel position in turn.
        for (int p = 0; p < N; p++) begin
            int w;
            for (int i = 0; i < N; i++) f_mp[i] = 8'd10;
            f_mp[p] = 8'd200;
            w = ((p / W) / 2) * (W / 2) + (p % W) / 2;
            clear_log();
            send_frame(f_mp, 1);
            flush();
            check($sformatf("maxpos%0d_count", p), out_log.size(), 4);
            for (int k = 0; k < 4 && k < out_log.size(); k++)
                check($sformatf("maxpos%0d_out%0d", p, k), {24'd0, out_log[k]}, (k == w) ? 32'd200 : 32'd10);
        end

        // Back-to-back frames with no idle cycle.
        clear_log();
        send_frame(f_up, 0);
        send_frame(f_dn, 0);
        flush();
        check("b2b_count", out_log.size(), 8);
        if (out_log.size() == 8) begin
            check("b2b_o0", {24'd0, out_log[0]}, 32'd5);
            check("b2b_o3", {24'd0, out_log[3]}, 32'd15);
            check("b2b_o4", {24'd0, out_log[4]}, 32'd15);
            check("b2b_o5", {24'd0, out_log[5]}, 32'd13);
            check("b2b_o6", {24'd0, out_log[6]}, 32'd7);
            check("b2b_o7", {24'd0, out_log[7]}, 32'd5);
        end
        check("b2b_fd", fd_cnt, 2);

        // Reset mid-frame, with a valid pixel on the reset cycle that must be dropped.
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, f_up[i]);
        step(1'b1, 1'b1, 8'hFF);
        step(1'b0, 1'b0, 8'd0);
        @(negedge clk_cal);
        check("midrst_omap", {24'd0, pif.OMap}, 32'd0);
        check("midrst_vld", {31'd0, pif.OMapVld}, 32'd0);
        clear_log();
        send_frame(f_up, 0);
        flush();
        check_log4("midrst", 8'd5, 8'd7, 8'd13, 8'd15, 1);

        // Clamp behaviour: one small positive value per window among sign-flagged values.
        for (int i = 0; i < N; i++) f_mp[i] = 8'h85;
        f_mp[0] = 8'h03; f_mp[7] = 8'h03; f_mp[12] = 8'h03; f_mp[14] = 8'h03;
        clear_log();
        send_frame(f_mp, 0);
        flush();
`ifdef POOL_RELU_EN
        check_log4("relu", 8'd3, 8'd3, 8'd3, 8'd3, 1);
`else
        check_log4("relu", 8'h85, 8'h85, 8'h85, 8'h85, 1);
`endif

        // Random stream with random gaps and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 70, 8'($urandom));
        end
        flush();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
